// File: rtl/slm_param_pkg.sv
// Shared widths, sign-magnitude offset type and command decode for the offset bank
// and the SDRAM-to-VGA-FIFO reader.
package slm_param_pkg;

  localparam int SLM_OFS_W   = 8;
  localparam int SLM_FRAME_W = 6;

  // Level the vsync synchronizer is preset to, so reset release never looks like an edge.
  localparam logic VS_IDLE = 1'b1;

  typedef struct packed {
    logic                 sign;
    logic [SLM_OFS_W-1:0] mag;
  } slm_ofs_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_INC,
    CMD_DEC
  } slm_cmd_e;

  // Load wins; inc and dec together cancel out.
  function automatic slm_cmd_e slm_cmd_decode(input logic load, input logic inc, input logic dec);
    slm_cmd_e cmd;
    if (load)
      cmd = CMD_LOAD;
    else if (inc ^ dec)
      cmd = inc ? CMD_INC : CMD_DEC;
    else
      cmd = CMD_NONE;
    return cmd;
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Brings the active-low VGA vsync into CLOCK_50 and flags its falling edge
// (2-flop synchronizer, delay flop, edge detector).
module vs_edge_sync
  import slm_param_pkg::*;
(
  input  logic CLOCK_50,
  input  logic delayed_reset,
  input  logic iVGA_VS,
  output logic oFALL
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q, dly_d;

  always_comb begin
    meta_d = iVGA_VS;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge CLOCK_50 or posedge delayed_reset) begin
    if (delayed_reset) begin
      meta_q <= VS_IDLE;
      sync_q <= VS_IDLE;
      dly_q  <= VS_IDLE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign oFALL = dly_q & ~sync_q;

endmodule

// File: rtl/slm_param_bank.sv
// Shadow/active offset and frame-ID bank. Define SLM_PARAM_VSYNC_COMMIT_EN to commit
// shadow -> active on the vsync falling edge; otherwise the active values follow writes directly.
module slm_param_bank
  import slm_param_pkg::*;
#(
  parameter int                      NUM_CH       = 2,
  parameter int                      OFS_W        = SLM_OFS_W,
  parameter int                      FRAME_W      = SLM_FRAME_W,
  parameter int                      STEP         = 1,
  parameter logic [NUM_CH*OFS_W-1:0] RST_MAG_VEC  = '0,
  parameter logic [NUM_CH-1:0]       RST_SIGN_VEC = '0,
  localparam int                     CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      CLOCK_50,
  input  logic                      delayed_reset,
  input  logic [CW-1:0]             iCH_SEL,
  input  logic [OFS_W-1:0]          iLOAD_MAG,
  input  logic                      iLOAD_SIGN,
  input  logic                      iLOAD,
  input  logic                      iINC,
  input  logic                      iDEC,
  input  logic [FRAME_W-1:0]        iFRAME_ID,
  input  logic                      iFRAME_LOAD,
  input  logic                      iVGA_VS,
  output logic [NUM_CH*OFS_W-1:0]   oOFFSET_MAG,
  output logic [NUM_CH-1:0]         oOFFSET_SIGN,
  output logic [FRAME_W-1:0]        oFRAME_ID,
  output logic                      oPENDING,
  output logic                      oCOMMIT
);

  // Two spare bits hold any |value| + STEP without overflow.
  localparam int                    SW      = OFS_W + 2;
  localparam logic [OFS_W-1:0]      MAG_MAX = '1;
  localparam logic signed [SW-1:0]  STEP_S  = SW'(STEP);
  localparam logic signed [SW-1:0]  MAX_S   = $signed({2'b00, MAG_MAX});

  // Signed step on a sign-magnitude value; negative zero enters as 0, zero leaves as +0.
  function automatic logic [OFS_W:0] step_val(input logic sign, input logic [OFS_W-1:0] mag,
                                              input logic up);
    logic signed [SW-1:0] v;
    logic signed [SW-1:0] r;
    logic signed [SW-1:0] a;
    logic [OFS_W-1:0]     m;
    v = $signed({2'b00, mag});
    if (sign)
      v = -v;
    r = up ? (v + STEP_S) : (v - STEP_S);
    a = r[SW-1] ? -r : r;
    m = (a > MAX_S) ? MAG_MAX : OFS_W'(a);
    return {r[SW-1], m};
  endfunction

  slm_cmd_e cmd;
  logic     ch_ok;
  logic     ch_wr;
  logic     wr_any;
  logic     commit_evt;
  logic     vs_in;

  always_comb begin
    cmd    = slm_cmd_decode(iLOAD, iINC, iDEC);
    ch_ok  = (int'(iCH_SEL) < NUM_CH);
    ch_wr  = ch_ok && (cmd != CMD_NONE);
    wr_any = ch_wr || iFRAME_LOAD;
  end

`ifdef SLM_PARAM_VSYNC_COMMIT_EN
  assign vs_in = iVGA_VS;
`else
  logic unused_vs;
  assign vs_in     = VS_IDLE;
  assign unused_vs = iVGA_VS ^ commit_evt;
`endif

  vs_edge_sync u_vs_edge_sync (
    .CLOCK_50      (CLOCK_50),
    .delayed_reset (delayed_reset),
    .iVGA_VS       (vs_in),
    .oFALL         (commit_evt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [OFS_W-1:0] sh_mag_q, sh_mag_d;
      logic             sh_sign_q, sh_sign_d;
      logic [OFS_W:0]   stepped;
      logic             sel;

      assign sel = ch_ok && (int'(iCH_SEL) == gi);

      always_comb begin
        stepped   = step_val(sh_sign_q, sh_mag_q, cmd == CMD_INC);
        sh_mag_d  = sh_mag_q;
        sh_sign_d = sh_sign_q;
        if (sel) begin
          case (cmd)
            CMD_LOAD: begin
              sh_mag_d  = iLOAD_MAG;
              sh_sign_d = iLOAD_SIGN;
            end
            CMD_INC, CMD_DEC: {sh_sign_d, sh_mag_d} = stepped;
            default: ;
          endcase
        end
      end

      always_ff @(posedge CLOCK_50 or posedge delayed_reset) begin
        if (delayed_reset) begin
          sh_mag_q  <= RST_MAG_VEC[gi*OFS_W +: OFS_W];
          sh_sign_q <= RST_SIGN_VEC[gi];
        end else begin
          sh_mag_q  <= sh_mag_d;
          sh_sign_q <= sh_sign_d;
        end
      end

`ifdef SLM_PARAM_VSYNC_COMMIT_EN
      logic [OFS_W-1:0] act_mag_q, act_mag_d;
      logic             act_sign_q, act_sign_d;

      // The active copy takes the shadow as it stood before this edge's write.
      always_comb begin
        act_mag_d  = commit_evt ? sh_mag_q  : act_mag_q;
        act_sign_d = commit_evt ? sh_sign_q : act_sign_q;
      end

      always_ff @(posedge CLOCK_50 or posedge delayed_reset) begin
        if (delayed_reset) begin
          act_mag_q  <= RST_MAG_VEC[gi*OFS_W +: OFS_W];
          act_sign_q <= RST_SIGN_VEC[gi];
        end else begin
          act_mag_q  <= act_mag_d;
          act_sign_q <= act_sign_d;
        end
      end

      assign oOFFSET_MAG[gi*OFS_W +: OFS_W] = act_mag_q;
      assign oOFFSET_SIGN[gi]               = act_sign_q;
`else
      assign oOFFSET_MAG[gi*OFS_W +: OFS_W] = sh_mag_q;
      assign oOFFSET_SIGN[gi]               = sh_sign_q;
`endif
    end
  endgenerate

  logic [FRAME_W-1:0] sh_frame_q, sh_frame_d;
  logic               commit_q, commit_d;

  always_comb begin
    sh_frame_d = iFRAME_LOAD ? iFRAME_ID : sh_frame_q;
  end

`ifdef SLM_PARAM_VSYNC_COMMIT_EN
  logic [FRAME_W-1:0] act_frame_q, act_frame_d;
  logic               pending_q, pending_d;

  // A write on the commit edge keeps pending set: it belongs to the next frame.
  always_comb begin
    act_frame_d = commit_evt ? sh_frame_q : act_frame_q;
    pending_d   = wr_any | (pending_q & ~commit_evt);
    commit_d    = commit_evt;
  end

  always_ff @(posedge CLOCK_50 or posedge delayed_reset) begin
    if (delayed_reset) begin
      act_frame_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      act_frame_q <= act_frame_d;
      pending_q   <= pending_d;
    end
  end

  assign oFRAME_ID = act_frame_q;
  assign oPENDING  = pending_q;
`else
  always_comb begin
    commit_d = wr_any;
  end

  assign oFRAME_ID = sh_frame_q;
  assign oPENDING  = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge delayed_reset) begin
    if (delayed_reset) begin
      sh_frame_q <= '0;
      commit_q   <= 1'b0;
    end else begin
      sh_frame_q <= sh_frame_d;
      commit_q   <= commit_d;
    end
  end

  assign oCOMMIT = commit_q;

endmodule

// File: doc/slm_param_bank.md
SLM_PARAM_BANK -- requirements
Module: slm_param_bank

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 2: number of offset channels (0 = horizontal, 1 = vertical).
REQ-002 The module SHALL have parameter OFS_W, default 8: offset magnitude width.
REQ-003 The module SHALL have parameter FRAME_W, default 6: frame-ID width.
REQ-004 The module SHALL have parameter STEP, default 1: inc/dec step magnitude, with 1 <= STEP < 2^OFS_W.
REQ-005 The module SHALL have parameter RST_MAG_VEC [NUM_CH*OFS_W-1:0], default 0: per-channel reset magnitude.
REQ-006 The module SHALL have parameter RST_SIGN_VEC [NUM_CH-1:0], default 0: per-channel reset sign.
REQ-007 The module SHALL have port CLOCK_50, input, 1 bit: system clock.
REQ-008 The module SHALL have port delayed_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The module SHALL have port iCH_SEL, input, CW = max(1, clog2(NUM_CH)) bits: target channel.
REQ-010 The module SHALL have port iLOAD_MAG, input, OFS_W bits: magnitude to load.
REQ-011 The module SHALL have port iLOAD_SIGN, input, 1 bit: sign to load (1 = negative).
REQ-012 The module SHALL have ports iLOAD, iINC and iDEC, inputs, 1 bit each: single-cycle command pulses.
REQ-013 The module SHALL have port iFRAME_ID, input, FRAME_W bits, and port iFRAME_LOAD, input, 1 bit: frame-ID write.
REQ-014 The module SHALL have port iVGA_VS, input, 1 bit: VGA vsync, active-low, asynchronous to CLOCK_50.
REQ-015 The module SHALL have port oOFFSET_MAG, output, NUM_CH*OFS_W bits: active magnitudes, channel 0 in the LSBs.
REQ-016 The module SHALL have port oOFFSET_SIGN, output, NUM_CH bits: active signs.
REQ-017 The module SHALL have port oFRAME_ID, output, FRAME_W bits: active frame ID.
REQ-018 The module SHALL have port oPENDING, output, 1 bit: shadow written since the last commit.
REQ-019 The module SHALL have port oCOMMIT, output, 1 bit: one-cycle pulse when the active registers load.

Function
REQ-020 Each channel and the frame ID SHALL hold a shadow register and an active register; commands write only the shadow register.
REQ-021 Commands SHALL be sampled each CLOCK_50 edge, and the shadow register SHALL update on that same edge.
REQ-022 Command priority SHALL be iLOAD > (iINC xor iDEC); iINC and iDEC asserted together SHALL leave the value unchanged.
REQ-023 A command with iCH_SEL >= NUM_CH SHALL be ignored, and it SHALL NOT set oPENDING.
REQ-024 Values SHALL be sign-magnitude; an increment SHALL add +STEP to the signed value and a decrement SHALL add -STEP.
REQ-025 If a step crosses zero, the sign SHALL flip and the magnitude SHALL become |result|.
REQ-026 A zero result SHALL be stored as sign 0.
REQ-027 A step SHALL saturate the magnitude at 2^OFS_W-1 in either direction, with no wrap.
REQ-028 A negative zero (sign 1, magnitude 0) SHALL be treated as 0 by inc/dec.
REQ-029 iLOAD SHALL store iLOAD_MAG and iLOAD_SIGN verbatim, including a negative zero.
REQ-030 iFRAME_LOAD SHALL be independent of the channel commands and SHALL be allowed in the same cycle as them.
REQ-031 iVGA_VS SHALL pass through a 2-flop synchronizer followed by a delay flop.
REQ-032 A commit event SHALL be the synchronized falling edge of iVGA_VS.
REQ-033 On a commit event, all active registers SHALL load from their shadow registers, oCOMMIT SHALL be 1 for one cycle, and oPENDING SHALL clear.
REQ-034 Outputs SHALL change exactly 3 rising edges after the first edge that samples iVGA_VS low.
REQ-035 On a commit coinciding with a write, the commit SHALL take the pre-write shadow and oPENDING SHALL stay 1.
REQ-036 Any accepted write SHALL set oPENDING on the next edge, including a write of an identical value.

Reset
REQ-037 Asserting delayed_reset SHALL immediately load each shadow and active channel with RST_MAG_VEC/RST_SIGN_VEC, set the frame ID to 0, and drive oPENDING = 0 and oCOMMIT = 0.
REQ-038 Asserting delayed_reset SHALL preset the synchronizer flops to 1 (vsync idle), so that no spurious commit occurs after reset release.
REQ-039 Asserting delayed_reset mid-operation SHALL discard pending shadow writes.

Configuration
REQ-040 With macro SLM_PARAM_VSYNC_COMMIT_EN defined, the module SHALL provide double-buffered commit per REQ-031 to REQ-036.
REQ-041 Without SLM_PARAM_VSYNC_COMMIT_EN, the active registers SHALL equal the shadow registers, updated on the command edge.
REQ-042 Without SLM_PARAM_VSYNC_COMMIT_EN, oCOMMIT SHALL pulse on each accepted write, oPENDING SHALL be tied to 0, and iVGA_VS SHALL be ignored.

Structure
REQ-043 Package slm_param_pkg SHALL hold the default widths (OFS_W, FRAME_W) and a sign-magnitude offset typedef, and shall be shared with the SDRAM-to-VGA-FIFO reader.
REQ-044 Sub-module vs_edge_sync SHALL contain the 2-flop synchronizer, the delay flop and the falling-edge detector.

Verification
REQ-045 Reset scenario: with RST_MAG_VEC = {8'd3, 8'd127} and RST_SIGN_VEC = 2'b01, release delayed_reset and toggle no vsync -> ch0 = -127, ch1 = +3, oPENDING = 0, oCOMMIT never asserted.
REQ-046 Load/commit scenario: iLOAD ch0 with mag 50, sign 0 -> oPENDING = 1 next edge and active still -127; then drop iVGA_VS low -> oCOMMIT pulses 3 edges later, ch0 = +50, oPENDING = 0.
REQ-047 Zero-crossing scenario: ch1 = -1, STEP = 1, iINC x2 -> shadow goes 0 (sign 0) then +1; with STEP = 4 and shadow -2, one iINC -> +2.
REQ-048 Saturation scenario: shadow +254, STEP = 4, iINC -> +255; iDEC from -255 -> -255; iINC & iDEC together -> unchanged.
REQ-049 Collision scenario: iLOAD in the same cycle as the commit edge -> active takes the old shadow and oPENDING stays 1; the next vsync commits the new value.
REQ-050 Out-of-range and build-variant scenario: iCH_SEL = 1 with NUM_CH = 1 -> no change, oPENDING = 0; a build without the macro -> iLOAD visible on the output the next edge, oCOMMIT pulses.
